// File: rtl/multdiv_pkg.sv
// ============================================================================
// multdiv_pkg : shared types and constants for the multiply/divide sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0]  OP_RTYPE            = 5'b00000;
  localparam logic [4:0]  ALU_MUL             = 5'b00110;
  localparam logic [4:0]  ALU_DIV             = 5'b00111;
  localparam logic [31:0] EXC_MUL             = 32'd4;
  localparam logic [31:0] EXC_DIV             = 32'd5;
  localparam logic [4:0]  RSTATUS_REG_DEFAULT = 5'd30;

  function automatic logic is_multdiv(input logic [4:0] opcode, input logic [4:0] alu_op);
    return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
  endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_iter.sv
// ============================================================================
// multdiv_iter : radix-2 shift-add multiplier / restoring divider datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              is_div,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  output logic [DATA_W-1:0] result,
  output logic              exception
);

  // hi:lo is the product for mul, remainder:quotient for div; md is the
  // magnitude of the multiplicand or divisor.
  logic [DATA_W-1:0]   hi, lo, md;
  logic                div_mode, negate, div_zero;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W-1:0]   hi_next, lo_next, diff;
  logic [DATA_W:0]     sum, shl;
  logic                ge;
  logic [2*DATA_W-1:0] prod_u, prod_s;
  logic [DATA_W-1:0]   quo_s;

  assign abs_a = operand_a[DATA_W-1] ? -operand_a : operand_a;
  assign abs_b = operand_b[DATA_W-1] ? -operand_b : operand_b;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      md       <= '0;
      div_mode <= 1'b0;
      negate   <= 1'b0;
      div_zero <= 1'b0;
    end else if (start) begin
      hi       <= '0;
      lo       <= is_div ? abs_a : abs_b;
      md       <= is_div ? abs_b : abs_a;
      div_mode <= is_div;
      negate   <= operand_a[DATA_W-1] ^ operand_b[DATA_W-1];
      div_zero <= (operand_b == '0);
    end else if (step) begin
      hi <= hi_next;
      lo <= lo_next;
    end
  end

  // The result port reflects the state after the iteration in flight, so the
  // sequencer captures the sign-corrected answer on the final step's edge.
  always_comb begin
    sum  = {1'b0, hi} + (lo[0] ? {1'b0, md} : '0);
    shl  = {hi, lo[DATA_W-1]};
    ge   = (shl >= {1'b0, md});
    diff = shl[DATA_W-1:0] - md;
    if (div_mode) begin
      hi_next = ge ? diff : shl[DATA_W-1:0];
      lo_next = {lo[DATA_W-2:0], ge};
    end else begin
      hi_next = sum[DATA_W:1];
      lo_next = {sum[0], lo[DATA_W-1:1]};
    end
    prod_u = {hi_next, lo_next};
    prod_s = negate ? -prod_u : prod_u;
    quo_s  = negate ? -lo_next : lo_next;
    if (div_mode) begin
      result    = quo_s;
      exception = div_zero;
    end else begin
      result    = prod_s[DATA_W-1:0];
      exception = ~((&prod_s[2*DATA_W-1:DATA_W-1]) | ~(|prod_s[2*DATA_W-1:DATA_W-1]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/multdiv_sequencer.sv
// ============================================================================
// multdiv_sequencer : stalls execute while mul/div iterates, then writes back
// Optional early-out for zero operands: MULTDIV_EARLY_OUT_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module multdiv_sequencer
  import multdiv_pkg::*;
#(
  parameter int         DATA_W      = 32,
  parameter int         ITERS       = 32,
  parameter logic [4:0] RSTATUS_REG = RSTATUS_REG_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [4:0]        opcode,
  input  logic [4:0]        alu_op,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [4:0]         rd_held;
  logic               op_div;
  logic               wb_pulse;
  logic               issue;
  logic               early;
  logic               last_iter;
  logic [DATA_W-1:0]  eng_result;
  logic               eng_exception;

  assign issue     = (state == IDLE) && in_valid && !flush && is_multdiv(opcode, alu_op);
  assign last_iter = (count == CNT_W'(ITERS - 1));

`ifdef MULTDIV_EARLY_OUT_EN
  // Divide-by-zero must still raise its exception, so it never short-cuts.
  assign early = (alu_op == ALU_DIV) ? ((operand_a == '0) && (operand_b != '0))
                                     : ((operand_a == '0) || (operand_b == '0));
`else
  assign early = 1'b0;
`endif

  assign stall = issue || (state == BUSY);
  assign busy  = (state != IDLE);
  // A flush landing on DONE kills the instruction, so its write is dropped.
  assign wb_en = wb_pulse && !flush;

  multdiv_iter #(
    .DATA_W(DATA_W)
  ) u_iter (
    .clock     (clock),
    .reset     (reset),
    .start     (issue),
    .step      (state == BUSY),
    .is_div    (alu_op == ALU_DIV),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (eng_result),
    .exception (eng_exception)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      rd_held  <= '0;
      op_div   <= 1'b0;
      wb_pulse <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
    end else begin
      wb_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            rd_held <= rd;
            op_div  <= (alu_op == ALU_DIV);
            count   <= '0;
            if (early) begin
              state    <= DONE;
              wb_pulse <= 1'b1;
              wb_reg   <= rd;
              wb_data  <= '0;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
          end else if (last_iter) begin
            state    <= DONE;
            wb_pulse <= 1'b1;
            if (eng_exception) begin
              wb_reg  <= RSTATUS_REG;
              wb_data <= op_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL);
            end else begin
              wb_reg  <= rd_held;
              wb_data <= eng_result;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// ============================================================================
// tb_multdiv_sequencer : directed bench with a cycle-offset reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [4:0]  alu_op = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  multdiv_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .opcode    (opcode),
    .alu_op    (alu_op),
    .rd        (rd),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clock) cyc = cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference model: outcome of an op computed with plain signed arithmetic.
  function automatic void predict(input logic [31:0] a, input logic [31:0] b, input bit is_div,
                                  input logic [4:0] r, output logic [4:0] er,
                                  output logic [31:0] ed, output int len);
    longint sa, sb, res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    len = 33;
    if (is_div) begin
      if (b == 32'd0) begin
        er = 5'd30; ed = 32'd5;
      end else begin
        res = sa / sb;
        er = r; ed = res[31:0];
      end
    end else begin
      res = sa * sb;
      if (res > 64'sd2147483647 || res < -64'sd2147483648) begin
        er = 5'd30; ed = 32'd4;
      end else begin
        er = r; ed = res[31:0];
      end
    end
`ifdef MULTDIV_EARLY_OUT_EN
    if ((!is_div && (a == 32'd0 || b == 32'd0)) || (is_div && a == 32'd0 && b != 32'd0)) begin
      er = r; ed = 32'd0; len = 1;
    end
`endif
  endfunction

  bit          m_active = 1'b0;
  int          m_t, m_len, rel;
  logic [4:0]  m_rreg, m_wreg = 5'd0;
  logic [31:0] m_rdata, m_wdata = 32'd0;
  bit          iss, e_stall, e_busy, e_wb;

  always @(negedge clock) begin
    if (cyc >= 1) begin
      iss = in_valid && opcode == 5'b00000 && (alu_op == 5'b00110 || alu_op == 5'b00111) && !flush;
      rel = cyc - m_t;
      if (m_active) begin
        e_busy  = 1'b1;
        e_stall = (rel < m_len);
        e_wb    = (rel == m_len) && !flush;
        if (rel == m_len) begin
          m_wreg  = m_rreg;
          m_wdata = m_rdata;
        end
      end else begin
        e_busy = 1'b0; e_wb = 1'b0; e_stall = iss;
      end
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("wb_en", {31'd0, wb_en}, {31'd0, e_wb});
      chk("wb_reg", {27'd0, wb_reg}, {27'd0, m_wreg});
      chk("wb_data", wb_data, m_wdata);
      if (reset) begin
        m_active = 1'b0; m_wreg = 5'd0; m_wdata = 32'd0;
      end else if (m_active) begin
        if (flush || rel == m_len) m_active = 1'b0;
      end else if (iss) begin
        m_active = 1'b1;
        m_t = cyc;
        predict(operand_a, operand_b, alu_op == 5'b00111, rd, m_rreg, m_rdata, m_len);
      end
    end
  end

  task automatic issue_op(input bit is_div, input logic [4:0] r, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #1;
    in_valid = 1'b1; opcode = 5'b00000; alu_op = is_div ? 5'b00111 : 5'b00110;
    rd = r; operand_a = a; operand_b = b; flush = 1'b0;
  endtask

  task automatic await_wb(input string nm, input int lat, input logic [4:0] er,
                          input logic [31:0] ed, output int t0);
    int st;
    bit got;
    t0 = cyc; st = 0; got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      @(negedge clock);
      if (stall) st++;
      if (wb_en) begin
        got = 1'b1;
        chk({nm, " latency"}, 32'(cyc - t0), 32'(lat));
        chk({nm, " stall cycles"}, 32'(st), 32'(lat));
        chk({nm, " wb_reg"}, {27'd0, wb_reg}, {27'd0, er});
        chk({nm, " wb_data"}, wb_data, ed);
      end
    end
    chk({nm, " wb seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic run(input string nm, input bit is_div, input logic [4:0] r, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [4:0] er, input logic [31:0] ed);
    int t0;
    issue_op(is_div, r, a, b);
    await_wb(nm, lat, er, ed, t0);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int ta, tb;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset wb_reg/data", {wb_reg, wb_data[26:0]}, 32'd0);

    run("mul 7*-3", 1'b0, 5'd5, 32'd7, -32'sd3, 33, 5'd5, 32'hFFFFFFEB);
    run("div -100/7", 1'b1, 5'd9, -32'sd100, 32'd7, 33, 5'd9, 32'hFFFFFFF2);
    run("div 5/0", 1'b1, 5'd3, 32'd5, 32'd0, 33, 5'd30, 32'd5);
    run("mul ovf", 1'b0, 5'd4, 32'h00010000, 32'h00010000, 33, 5'd30, 32'd4);
    run("div min/-1", 1'b1, 5'd7, 32'h80000000, 32'hFFFFFFFF, 33, 5'd7, 32'h80000000);
    run("mul min*1", 1'b0, 5'd12, 32'h80000000, 32'd1, 33, 5'd12, 32'h80000000);
    run("mul min*-1", 1'b0, 5'd13, 32'h80000000, 32'hFFFFFFFF, 33, 5'd30, 32'd4);
    run("mul rd0", 1'b0, 5'd0, 32'd2, 32'd3, 33, 5'd0, 32'd6);
    run("div 1000/-33", 1'b1, 5'd14, 32'd1000, -32'sd33, 33, 5'd14, 32'hFFFFFFE2);

    // Back-to-back: the first instruction stays in execute through DONE.
    issue_op(1'b0, 5'd1, 32'd3, 32'd4);
    await_wb("b2b first", 33, 5'd1, 32'd12, ta);
    issue_op(1'b0, 5'd2, -32'sd2, -32'sd5);
    await_wb("b2b second", 33, 5'd2, 32'd10, tb);
    chk("b2b issue spacing", 32'(tb - ta), 32'd34);
    @(posedge clock); #1 in_valid = 1'b0;

    // Flush in the issue cycle and non-matching decodes never stall.
    @(posedge clock); #1;
    in_valid = 1'b1; opcode = 5'd0; alu_op = 5'b00110; flush = 1'b1;
    @(posedge clock); #1 alu_op = 5'b00101; flush = 1'b0;
    @(posedge clock); #1 opcode = 5'b00001; alu_op = 5'b00111;
    @(negedge clock);
    chk("no issue busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1 in_valid = 1'b0; opcode = 5'd0;

    // Flush mid-operation.
    issue_op(1'b0, 5'd6, 32'd100, 32'd200);
    repeat (10) @(posedge clock);
    #1 flush = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1 flush = 1'b0;
    @(negedge clock);
    chk("post-flush stall", {31'd0, stall}, 32'd0);
    chk("post-flush busy", {31'd0, busy}, 32'd0);

    // Reset mid-operation.
    issue_op(1'b1, 5'd8, 32'd77, 32'd7);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1; in_valid = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("post-reset stall/busy/wb_en", {29'd0, stall, busy, wb_en}, 32'd0);
    chk("post-reset wb_data", wb_data, 32'd0);
    run("mul after reset", 1'b0, 5'd11, 32'd6, 32'd7, 33, 5'd11, 32'd42);

`ifdef MULTDIV_EARLY_OUT_EN
    run("mul 0*12345", 1'b0, 5'd15, 32'd0, 32'd12345, 1, 5'd15, 32'd0);
    run("div 0/7", 1'b1, 5'd16, 32'd0, 32'd7, 1, 5'd16, 32'd0);
`else
    run("mul 0*12345", 1'b0, 5'd15, 32'd0, 32'd12345, 33, 5'd15, 32'd0);
`endif
    run("div 9/0", 1'b1, 5'd17, 32'd9, 32'd0, 33, 5'd30, 32'd5);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle sequencer for the processor's iterative multiply/divide resource. It sits in the execute stage beside the single-cycle ALU and detects R-type `mul`/`div` instructions. It stalls the pipeline while a shared radix-2 engine iterates, then issues exactly one register-file writeback: the result, or an exception code to `$rstatus`.

## Interface
Parameters:
- `DATA_W`, 32 – operand/result width.
- `ITERS`, 32 – engine iterations per operation; must equal `DATA_W`.
- `RSTATUS_REG`, 5'd30 – destination register for exception codes.

Ports:
- `clock` in 1 – single clock.
- `reset` in 1 – **synchronous, active-high**.
- `in_valid` in 1 – valid instruction present in execute.
- `opcode` in 5 – instruction opcode.
- `alu_op` in 5 – R-type ALU op field.
- `rd` in 5 – destination register.
- `operand_a` in DATA_W – rs value (dividend / multiplicand).
- `operand_b` in DATA_W – rt value (divisor / multiplier).
- `flush` in 1 – kill the instruction in execute (taken branch/jump).
- `stall` out 1 – freeze PC and the F/D/X latches.
- `busy` out 1 – engine occupied (state ≠ IDLE).
- `wb_en` out 1 – one-cycle register write strobe.
- `wb_reg` out 5 – write address.
- `wb_data` out DATA_W – write data.

## Operation
- Issue condition: state IDLE, `in_valid`, `opcode`=00000, `alu_op`∈{00110 mul, 00111 div}, and `!flush`.
- On issue:
  - latch operands, `rd`, op kind;
  - start the engine;
  - `stall`=1 combinationally in the issue cycle.
- FSM transitions:
  - IDLE→BUSY on issue.
  - BUSY→DONE when the iteration counter reaches `ITERS`-1.
  - DONE→IDLE unconditionally.
  - Any state→IDLE on `reset`.
  - BUSY/DONE→IDLE on `flush`, with no writeback.
- DONE behaviour:
  - `stall`=0, so the held instruction advances.
  - `wb_en`=1 for that single cycle.
  - No new issue is accepted in DONE. This prevents the still-present instruction from re-issuing.
- mul: signed 32×32. `wb_data` = low 32 bits of the product. Overflow occurs when the upper 33 bits of the 64-bit product are not all equal.
- div: signed quotient, truncated toward zero; remainder discarded. 0x80000000 / −1 yields 0x80000000 with no exception.
- Exceptions (mul overflow, div by zero):
  - `wb_reg`=`RSTATUS_REG`.
  - `wb_data`=4 for mul, 5 for div.
  - The result is discarded.
- Otherwise `wb_reg`=latched `rd`.
- `rd`=0 and no exception: `wb_en` is still pulsed; the register file ignores writes to r0.
- Reset values of every output: `stall`=0, `busy`=0, `wb_en`=0, `wb_reg`=0, `wb_data`=0. The counter clears and state returns to IDLE.

## Timing
- Issue at cycle T.
- BUSY during T+1..T+ITERS. DONE at T+ITERS+1 (T+33 at default). Writeback strobe is in DONE.
- `stall` is high T..T+ITERS inclusive, for ITERS+1 cycles.
- Earliest next issue: T+ITERS+2, so back-to-back mul/div cost 34 cycles each.
- `flush` in the issue cycle suppresses the issue.
- `flush` while BUSY: state is IDLE next cycle and `stall` drops the same cycle.
- `reset` mid-operation: engine aborted, no writeback, outputs at reset values the next cycle.
- `wb_reg`/`wb_data` are registered and valid only while `wb_en`=1. Otherwise they hold their last values.

## Configuration
- `MULTDIV_EARLY_OUT_EN` defined:
  - A mul with either operand zero completes with result 0.
  - A div with dividend zero and non-zero divisor completes with result 0.
  - Both skip BUSY: IDLE→DONE directly, with DONE at T+1 and `stall` high only in cycle T.
  - Divide-by-zero is never early-out and follows the full path.
- Undefined: every operation takes the full ITERS+1-cycle stall.

## Structure
- Package `multdiv_pkg` holds:
  - state enum {IDLE, BUSY, DONE};
  - constants OP_RTYPE=5'b00000, ALU_MUL=5'b00110, ALU_DIV=5'b00111;
  - EXC_MUL=32'd4, EXC_DIV=32'd5;
  - RSTATUS_REG default.
- Sub-module `multdiv_iter` is the shift-add / restoring-divide datapath:
  - inputs `start`, `is_div`, operands;
  - outputs `result`, `exception`;
  - one iteration per clock;
  - sign fix-up applied on the final iteration.
- The sequencer owns the FSM, counter, issue decode, flush handling and writeback registers.

## Test plan
- mul 7 × −3, rd=5 → `stall` high 33 cycles; DONE at T+33 with `wb_en`=1, `wb_reg`=5, `wb_data`=0xFFFFFFEB.
- div −100 / 7, rd=9 → `wb_data`=0xFFFFFFF2 (−14), `wb_reg`=9, single `wb_en` pulse.
- div 5 / 0 → `wb_reg`=30, `wb_data`=5. mul 0x10000 × 0x10000 → `wb_reg`=30, `wb_data`=4.
- Back-to-back muls held in execute → exactly one writeback per instruction; second issue at T+34; no re-issue in DONE.
- `flush` at T+10, then `reset` asserted at T+5 of a fresh op → no `wb_en`; `stall`/`busy` 0 the following cycle; new issue accepted next IDLE cycle.
- With `MULTDIV_EARLY_OUT_EN`: mul 0 × 12345 → `wb_en` at T+1, `wb_data`=0, `stall` high one cycle. Div 9 / 0 → full 33-cycle path with code 5.
